// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller. Detects load-use hazards between execute and
//   decode, sequences branch-mispredict flushes, and stalls the front end
//   while a data-memory access is outstanding (with a sticky timeout flag).
//
// Ports
//   clk         pipeline clock, rising edge
//   rstn        asynchronous active-low reset
//   instr_id    instruction presented to decode
//   id_valid    decode holds a real instruction
//   exe_opcode  opcode of the instruction in execute
//   exe_rd      destination register of the instruction in execute
//   exe_valid   execute holds a real instruction
//   mispredict  single-cycle pulse, control-flow resolved against prediction
//   dmem_req    data-memory request outstanding
//   dmem_ack    data-memory request completes this cycle
//   ide_wait    decode stall
//   if_stall    fetch holds PC and instruction
//   flush_if    invalidate fetch register
//   flush_id    invalidate decode register
//   mem_err     sticky data-memory timeout flag
//   stall_cnt   saturating count of cycles with ide_wait high
//   state_o     FSM state for debug (RUN=00, LDUSE=01, FLUSH=10, MEMWAIT=11)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter logic [7:0] MEM_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr_id,
  input  logic        id_valid,
  input  logic [6:0]  exe_opcode,
  input  logic [4:0]  exe_rd,
  input  logic        exe_valid,
  input  logic        mispredict,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        ide_wait,
  output logic        if_stall,
  output logic        flush_if,
  output logic        flush_id,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDUSE   = 2'b01,
    FLUSH   = 2'b10,
    MEMWAIT = 2'b11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q;
  logic [1:0]  flush_ctr_q;
  logic [7:0]  wait_ctr_q;
  logic [7:0]  wait_ctr_d;
  logic        pend_flush_q;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;

  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;

  // Only opcode and source-register fields matter for hazard detection.
  logic        unused_instr_bits;
  assign unused_instr_bits = ^{instr_id[31:25], instr_id[14:7]};

  assign id_opcode = instr_id[6:0];
  assign id_rs1    = instr_id[19:15];
  assign id_rs2    = instr_id[24:20];

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_opcode)
      OP_LOAD, OP_IMM, OP_JALR:     use_rs1 = 1'b1;
      OP_STORE, OP_REG, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign hazard = id_valid & exe_valid & (exe_opcode == OP_LOAD) & (exe_rd != 5'd0) &
                  ((use_rs1 & (exe_rd == id_rs1)) | (use_rs2 & (exe_rd == id_rs2)));

  // Wait counter saturates so a very long wait cannot wrap back below the
  // timeout threshold.
  assign wait_ctr_d = (wait_ctr_q == 8'hFF) ? 8'hFF : wait_ctr_q + 8'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= RUN;
      flush_ctr_q  <= 2'd0;
      wait_ctr_q   <= 8'd0;
      pend_flush_q <= 1'b0;
      mem_err_q    <= 1'b0;
      stall_cnt_q  <= 16'd0;
    end else begin
      if ((state_q != RUN) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end

      case (state_q)
        RUN: begin
          // An ack in the same cycle as the request does not need a wait.
          if (mispredict) begin
            state_q     <= FLUSH;
            flush_ctr_q <= 2'd2;
          end else if (dmem_req & ~dmem_ack) begin
            state_q    <= MEMWAIT;
            wait_ctr_q <= 8'd0;
          end else if (hazard) begin
            state_q <= LDUSE;
          end
        end

        LDUSE: begin
          if (mispredict) begin
            state_q     <= FLUSH;
            flush_ctr_q <= 2'd2;
          end else begin
            state_q <= RUN;
          end
        end

        FLUSH: begin
          // A fresh mispredict restarts the two-cycle flush window.
          if (mispredict) begin
            flush_ctr_q <= 2'd2;
          end else if (flush_ctr_q <= 2'd1) begin
            state_q     <= RUN;
            flush_ctr_q <= 2'd0;
          end else begin
            flush_ctr_q <= flush_ctr_q - 2'd1;
          end
        end

        MEMWAIT: begin
          if (dmem_ack) begin
            // A mispredict seen during the wait is replayed once memory is done.
            if (pend_flush_q | mispredict) begin
              state_q     <= FLUSH;
              flush_ctr_q <= 2'd2;
            end else begin
              state_q <= RUN;
            end
            pend_flush_q <= 1'b0;
          end else begin
            wait_ctr_q <= wait_ctr_d;
            if (wait_ctr_d == MEM_TIMEOUT) begin
              mem_err_q <= 1'b1;
            end
            if (mispredict) begin
              pend_flush_q <= 1'b1;
            end
          end
        end

        default: state_q <= RUN;
      endcase
    end
  end

  assign ide_wait  = (state_q != RUN);
  assign if_stall  = (state_q == LDUSE) || (state_q == MEMWAIT);
  assign flush_if  = (state_q == FLUSH);
  assign flush_id  = (state_q == FLUSH);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr_id;
  logic        id_valid;
  logic [6:0]  exe_opcode;
  logic [4:0]  exe_rd;
  logic        exe_valid;
  logic        mispredict;
  logic        dmem_req;
  logic        dmem_ack;
  logic        ide_wait;
  logic        if_stall;
  logic        flush_if;
  logic        flush_id;
  logic        mem_err;
  logic [15:0] stall_cnt;
  logic [1:0]  state_o;

  logic [6:0]  obs;
  assign obs = {ide_wait, if_stall, flush_if, flush_id, mem_err, state_o};

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of flush still to show, pending load-use bubble,
  // memory-wait bookkeeping, sticky error, stall total.
  int m_flush_left;
  bit m_ld;
  bit m_mem;
  bit m_pend;
  bit m_err;
  int m_waited;
  int m_stalls;

  hazard_ctrl #(.MEM_TIMEOUT(8'd255)) dut (
    .clk(clk), .rstn(rstn), .instr_id(instr_id), .id_valid(id_valid),
    .exe_opcode(exe_opcode), .exe_rd(exe_rd), .exe_valid(exe_valid),
    .mispredict(mispredict), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .ide_wait(ide_wait), .if_stall(if_stall), .flush_if(flush_if),
    .flush_id(flush_id), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bit ref_hazard();
    logic [6:0] op;
    bit r1, r2;
    op = instr_id[6:0];
    r1 = op inside {7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1100011, 7'b1100111};
    r2 = op inside {7'b0100011, 7'b0110011, 7'b1100011};
    return id_valid && exe_valid && (exe_opcode == 7'b0000011) && (exe_rd != 0) &&
           ((r1 && exe_rd == instr_id[19:15]) || (r2 && exe_rd == instr_id[24:20]));
  endfunction

  function automatic logic [6:0] exp_vec();
    logic fl;
    logic [1:0] st;
    fl = (m_flush_left > 0);
    st = fl ? 2'b10 : m_mem ? 2'b11 : m_ld ? 2'b01 : 2'b00;
    return {fl || m_ld || m_mem, m_ld || m_mem, fl, fl, m_err, st};
  endfunction

  task automatic model_clear();
    m_flush_left = 0; m_ld = 0; m_mem = 0; m_pend = 0;
    m_err = 0; m_waited = 0; m_stalls = 0;
  endtask

  task automatic idle_inputs();
    instr_id = 32'h0000_0013; id_valid = 0; exe_opcode = 7'b0010011;
    exe_rd = 0; exe_valid = 0; mispredict = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Advance model by the current inputs, then clock the DUT.
  task automatic tick();
    bit busy, hz;
    busy = (m_flush_left > 0) || m_ld || m_mem;
    hz = ref_hazard();
    if (busy && m_stalls < 65535) m_stalls++;
    if (m_flush_left > 0) begin
      if (mispredict) m_flush_left = 2; else m_flush_left--;
    end else if (m_ld) begin
      m_ld = 0;
      if (mispredict) m_flush_left = 2;
    end else if (m_mem) begin
      if (dmem_ack) begin
        m_mem = 0;
        if (m_pend || mispredict) m_flush_left = 2;
        m_pend = 0;
      end else begin
        if (mispredict) m_pend = 1;
        if (m_waited < 255) m_waited++;
        if (m_waited == TIMEOUT) m_err = 1;
      end
    end else begin
      if (mispredict) m_flush_left = 2;
      else if (dmem_req && !dmem_ack) begin m_mem = 1; m_waited = 0; end
      else if (hz) m_ld = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    model_clear();
    #1;
    checks++;
    if (obs !== 7'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b cnt=%0d exp=0000000 cnt=0", obs, stall_cnt);
    end
    @(posedge clk); #1;
    rstn = 1;
    tick();
    checks++;
    if (obs !== exp_vec() || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_release got=%b cnt=%0d exp=%b cnt=0", obs, stall_cnt, exp_vec());
    end
  endtask

  task automatic test_load_use();
    int ide_n, ifs_n;
    ide_n = 0; ifs_n = 0;
    do_reset();
    exe_opcode = 7'b0000011; exe_rd = 5'd5; exe_valid = 1;
    instr_id = {7'd0, 5'd7, 5'd5, 3'b000, 5'd6, 7'b0110011}; // add x6,x5,x7
    id_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exe_valid = 0; // the load has moved on after one cycle
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL load_use_c%0d got=%b exp=%b", i, obs, exp_vec());
      end
      ide_n += int'(ide_wait);
      ifs_n += int'(if_stall);
    end
    checks++;
    if (ide_n != 1 || ifs_n != 1 || stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL load_use_len ide=%0d ifs=%0d cnt=%0d exp 1 1 1", ide_n, ifs_n, stall_cnt);
    end
  endtask

  task automatic test_false_hazard();
    int ide_n;
    ide_n = 0;
    do_reset();
    id_valid = 1; exe_valid = 1;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin exe_opcode = 7'b0000011; exe_rd = 5'd0;
                 instr_id = {7'd0, 5'd7, 5'd0, 3'b000, 5'd6, 7'b0110011}; end
        1: begin exe_opcode = 7'b0000011; exe_rd = 5'd5;
                 instr_id = {12'h000, 5'd5, 3'b000, 5'd6, 7'b0110111}; end // lui
        default: begin exe_opcode = 7'b0010011; exe_rd = 5'd5;
                 instr_id = {7'd0, 5'd5, 5'd5, 3'b000, 5'd6, 7'b0110011}; end
      endcase
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL false_hazard_%0d got=%b exp=%b", k, obs, exp_vec());
      end
      ide_n += int'(ide_wait);
    end
    checks++;
    if (ide_n != 0) begin
      errors++;
      $display("FAIL false_hazard_stalls got=%0d exp=0", ide_n);
    end
  endtask

  task automatic test_mispredict();
    int fl_n, ifs_n;
    for (int pass = 0; pass < 2; pass++) begin
      fl_n = 0; ifs_n = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
        // pass 1 repeats the pulse while in the second flush cycle
        mispredict = (i == 0) || (pass == 1 && i == 2);
        tick();
        checks++;
        if (obs !== exp_vec()) begin
          errors++;
          $display("FAIL mispredict_p%0d_c%0d got=%b exp=%b", pass, i, obs, exp_vec());
        end
        fl_n += int'(flush_if && flush_id && ide_wait);
        ifs_n += int'(if_stall);
      end
      checks++;
      if (fl_n != (pass == 0 ? 2 : 4) || ifs_n != 0) begin
        errors++;
        $display("FAIL mispredict_len_p%0d flush=%0d ifs=%0d exp %0d 0", pass, fl_n, ifs_n,
                 pass == 0 ? 2 : 4);
      end
    end
  endtask

  task automatic test_memwait();
    int mw_n, fl_n;
    mw_n = 0; fl_n = 0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      dmem_req = (i <= 5);
      dmem_ack = (i == 5);
      mispredict = (i == 2);
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL memwait_c%0d got=%b exp=%b", i, obs, exp_vec());
      end
      mw_n += int'(state_o == 2'b11);
      fl_n += int'(flush_if);
    end
    checks++;
    if (mw_n != 5 || fl_n != 2 || stall_cnt !== 16'd7) begin
      errors++;
      $display("FAIL memwait_len mw=%0d fl=%0d cnt=%0d exp 5 2 7", mw_n, fl_n, stall_cnt);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    ops = '{7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011,
            7'b1100011, 7'b1100111, 7'b0110111, 7'b1101111};
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instr_id = {7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b000,
                  5'd1, ops[$urandom_range(0, 7)]};
      id_valid   = ($urandom_range(0, 3) != 0);
      exe_opcode = ($urandom_range(0, 1) == 0) ? 7'b0000011 : ops[$urandom_range(0, 7)];
      exe_rd     = 5'($urandom_range(0, 3));
      exe_valid  = ($urandom_range(0, 3) != 0);
      mispredict = ($urandom_range(0, 9) == 0);
      dmem_req   = ($urandom_range(0, 3) == 0);
      dmem_ack   = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (obs !== exp_vec() || stall_cnt !== 16'(m_stalls)) begin
        errors++;
        $display("FAIL random_c%0d got=%b cnt=%0d exp=%b cnt=%0d", i, obs, stall_cnt,
                 exp_vec(), m_stalls);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1;
    repeat (255) tick();
    checks++;
    if (mem_err !== 1'b0 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_early got=%b exp=%b", obs, exp_vec());
    end
    tick();
    checks++;
    if (mem_err !== 1'b1 || state_o !== 2'b11 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_set got=%b exp=%b", obs, exp_vec());
    end
    repeat (4) tick();
    checks++;
    if (mem_err !== 1'b1 || state_o !== 2'b11) begin
      errors++;
      $display("FAIL timeout_hold err=%b st=%b exp 1 11", mem_err, state_o);
    end
    rstn = 0;
    model_clear();
    #1;
    checks++;
    if (obs !== 7'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL timeout_reset got=%b cnt=%0d exp=0000000 cnt=0", obs, stall_cnt);
    end
    @(posedge clk); #1;
    rstn = 1;
  endtask

  task automatic test_reset_midop();
    do_reset();
    mispredict = 1;
    tick();
    mispredict = 0;
    rstn = 0;
    model_clear();
    #1;
    checks++;
    if (obs !== 7'd0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midop_reset got=%b cnt=%0d exp=0000000 cnt=0", obs, stall_cnt);
    end
    @(posedge clk); #1;
    rstn = 1;
    tick();
    checks++;
    if (obs !== exp_vec() || state_o !== 2'b00) begin
      errors++;
      $display("FAIL midop_release got=%b exp=%b", obs, exp_vec());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    dmem_req = 1;
    repeat (70000) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF || stall_cnt !== 16'(m_stalls)) begin
      errors++;
      $display("FAIL saturate got=%h exp=ffff", stall_cnt);
    end
    repeat (5) tick();
    checks++;
    if (stall_cnt !== 16'hFFFF || obs !== exp_vec()) begin
      errors++;
      $display("FAIL saturate_hold got=%h vec=%b exp=ffff vec=%b", stall_cnt, obs, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_false_hazard();
    test_mispredict();
    test_memwait();
    test_random();
    test_timeout();
    test_reset_midop();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 8'd255, data-memory wait cycles before the error flag sets.
REQ-002 SHALL have port clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port instr_id  input  32  instruction currently presented to decode.
REQ-005 SHALL have port id_valid  input  1  instr_id holds a real instruction, not a bubble.
REQ-006 SHALL have port exe_opcode  input  7  opcode of the instruction in execute.
REQ-007 SHALL have port exe_rd  input  5  destination register of the instruction in execute.
REQ-008 SHALL have port exe_valid  input  1  execute holds a real instruction.
REQ-009 SHALL have port mispredict  input  1  single-cycle pulse: execute resolved a branch, jal or jalr against the prediction.
REQ-010 SHALL have port dmem_req  input  1  data-memory request outstanding.
REQ-011 SHALL have port dmem_ack  input  1  data-memory request completes this cycle.
REQ-012 SHALL have port ide_wait  output  1  decode stall; drives the decoder stall input.
REQ-013 SHALL have port if_stall  output  1  fetch holds the PC and instruction.
REQ-014 SHALL have port flush_if  output  1  fetch register is invalidated.
REQ-015 SHALL have port flush_id  output  1  decode register is invalidated.
REQ-016 SHALL have port mem_err  output  1  sticky data-memory timeout flag.
REQ-017 SHALL have port stall_cnt  output  16  saturating count of cycles with ide_wait high.
REQ-018 SHALL have port state_o  output  2  FSM state for debug: RUN=00, LDUSE=01, FLUSH=10, MEMWAIT=11.

Function
REQ-019 SHALL compute hazard = id_valid & exe_valid & (exe_opcode==7'b0000011) & (exe_rd!=0) & ((use_rs1 & exe_rd==instr_id[19:15]) | (use_rs2 & exe_rd==instr_id[24:20])).
REQ-020 SHALL set use_rs1 for decode opcodes 0000011, 0100011, 0010011, 0110011, 1100011 and 1100111.
REQ-021 SHALL set use_rs2 for decode opcodes 0100011, 0110011 and 1100011.
REQ-022 SHALL decode RUN transitions in priority order:
- mispredict -> FLUSH with flush_ctr=2.
- dmem_req & ~dmem_ack -> MEMWAIT.
- hazard -> LDUSE.
- otherwise stay in RUN.
REQ-023 SHALL make LDUSE last exactly one cycle, then go to RUN; a mispredict seen while in LDUSE SHALL go to FLUSH instead.
REQ-024 SHALL decrement flush_ctr each cycle in FLUSH and return to RUN after the cycle in which flush_ctr reaches 1, so FLUSH lasts 2 cycles.
REQ-025 SHALL, on a mispredict while in FLUSH, reload flush_ctr to 2, extending FLUSH to 2 cycles from that point.
REQ-026 SHALL hold MEMWAIT until dmem_ack, then:
- if pend_flush is set, or mispredict is high in the ack cycle, go to FLUSH with flush_ctr=2;
- otherwise go to RUN.
REQ-027 SHALL, on a mispredict while in MEMWAIT without ack, set pend_flush; pend_flush SHALL clear when FLUSH is entered.
REQ-028 SHALL clear the 8-bit wait_ctr on entry to MEMWAIT and increment it each MEMWAIT cycle.
REQ-029 SHALL set mem_err when wait_ctr equals MEM_TIMEOUT; mem_err SHALL stay set until reset, and the FSM SHALL stay in MEMWAIT.
REQ-030 SHALL decode outputs from registered state only (Moore):
- ide_wait = state != RUN;
- if_stall = state is LDUSE or MEMWAIT;
- flush_if = flush_id = state is FLUSH.
REQ-031 SHALL increment stall_cnt in each cycle where ide_wait=1 and saturate it at 16'hFFFF.
REQ-032 SHALL ignore dmem_ack outside MEMWAIT, and SHALL ignore dmem_ack arriving in the same cycle as dmem_req in RUN.

Reset
REQ-033 SHALL, while rstn=0, immediately force: state=RUN, flush_ctr=0, wait_ctr=0, pend_flush=0, mem_err=0, stall_cnt=0, and all of ide_wait, if_stall, flush_if and flush_id low.
REQ-034 SHALL abandon any LDUSE, FLUSH or MEMWAIT sequence when reset asserts mid-operation; the first cycle after rstn deasserts SHALL be in RUN.

Verification
REQ-035 SHALL cover load-use: exe lw with x5, decode add x6,x5,x7 -> ide_wait=1 and if_stall=1 for exactly 1 cycle, stall_cnt=1.
REQ-036 SHALL cover false hazards: exe lw with x0, or decode lui with x5 -> no stall.
REQ-037 SHALL cover mispredict, including a second mispredict:
- single pulse -> flush_if=flush_id=1 for 2 cycles, ide_wait=1, if_stall=0;
- second pulse in flush cycle 2 -> 2 further flush cycles.
REQ-038 SHALL cover memory wait: dmem_req high for 5 cycles then ack -> MEMWAIT for 5 cycles; a mispredict in MEMWAIT cycle 2 -> FLUSH for 2 cycles after ack.
REQ-039 SHALL cover timeout: dmem_req with no ack for 256 cycles -> mem_err=1 when wait_ctr=255, FSM remains in MEMWAIT; asserting rstn low then clears every output.
REQ-040 SHALL cover counter saturation: force a stall for 70000 cycles -> stall_cnt=16'hFFFF and holds there.
